// File: rtl/operand_regfile.sv
// ---------------------------------------------------------------------------
// operand_regfile
//
// Purpose:
//   Register file and operand-latch stage directly upstream of the ALU.
//   Holds 2**ADDR_W general registers, with r0 hardwired to zero. It presents
//   two registered operands, a_out and b_out, to ALU Ain/Bin with 1-cycle
//   latency.
//
//   Two mechanisms keep the operands coherent without a forwarding unit:
//   - Same-cycle write-to-read bypass: an issue that reads the register being
//     written this cycle captures the new write data.
//   - Stall-hold refresh: while the ALU stalls, a held operand whose source
//     register is overwritten picks up the new value.
//
// Ports:
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous reset, active-high
//   rd_en     in   1       issue: capture operands for ra_addr/rb_addr
//   stall     in   1       ALU busy: hold a_out/b_out/out_valid
//   ra_addr   in   ADDR_W  source register A
//   rb_addr   in   ADDR_W  source register B
//   we        in   1       write-back enable
//   wa_addr   in   ADDR_W  write-back destination register
//   wd        in   DATA_W  write-back data
//   a_out     out  DATA_W  registered operand A
//   b_out     out  DATA_W  registered operand B
//   out_valid out  1       a_out/b_out hold a valid issued operand pair
// ---------------------------------------------------------------------------
module operand_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              stall,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              out_valid
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;

  logic              wr_hit;
  logic [DATA_W-1:0] a_rd;
  logic [DATA_W-1:0] b_rd;

  // A write that actually lands; writes to r0 are discarded.
  assign wr_hit = we && (wa_addr != '0);

  // Read muxes with same-cycle bypass. r0 is forced to zero explicitly, so
  // the zero does not depend on regs[0] never being written.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    a_rd = '0;
    b_rd = '0;
    if (ra_addr != '0) a_rd = (wr_hit && (wa_addr == ra_addr)) ? wd : regs[ra_addr];
    if (rb_addr != '0) b_rd = (wr_hit && (wa_addr == rb_addr)) ? wd : regs[rb_addr];
  end

  // Register array. Writes land regardless of stall or rd_en.
  // NOTE: the array is cleared on reset because all registers must read 0
  // afterwards. This rules out inferring block RAM, which is acceptable for
  // a file this small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // always_ff samples pre-edge values regardless of evaluation order.
      regs[wa_addr] <= wd;
    end
  end

  // Operand latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else if (!stall) begin
      out_valid <= rd_en;
      if (rd_en) begin
        a_out <= a_rd;
        b_out <= b_rd;
        a_q   <= ra_addr;
        b_q   <= rb_addr;
      end
    end else begin
      // Stalled: a held, valid operand tracks writes to its source register.
      if (out_valid && wr_hit && (wa_addr == a_q)) a_out <= wd;
      if (out_valid && wr_hit && (wa_addr == b_q)) b_out <= wd;
    end
  end

endmodule

// File: tb/tb_operand_regfile.sv
// ---------------------------------------------------------------------------
// tb_operand_regfile
//
// Self-checking bench for operand_regfile.
//
// Reference model:
//   The model keeps an array of architectural register values. While an
//   operand pair is valid, each operand is defined as the current contents of
//   its bound source register. Once the pair goes invalid, the operand freezes
//   at whatever it last showed.
//
// Test sequence:
//   - Directed scenarios with constant expectations.
//   - A randomized run checked against the model on every cycle.
// ---------------------------------------------------------------------------
module tb_operand_regfile;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] ra_addr = '0;
  logic [AW-1:0] rb_addr = '0;
  logic          we = 1'b0;
  logic [AW-1:0] wa_addr = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic          out_valid;

  operand_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .stall(stall),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .we(we), .wa_addr(wa_addr),
    .wd(wd), .a_out(a_out), .b_out(b_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW-1:0] m_regs [NR];
  logic          m_valid;
  logic [AW-1:0] m_asrc, m_bsrc;
  logic [DW-1:0] m_ahold, m_bhold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_valid = 1'b0;
    m_asrc  = '0;
    m_bsrc  = '0;
    m_ahold = '0;
    m_bhold = '0;
  endtask

  function automatic logic [DW-1:0] exp_a();
    return m_valid ? m_regs[m_asrc] : m_ahold;
  endfunction

  function automatic logic [DW-1:0] exp_b();
    return m_valid ? m_regs[m_bsrc] : m_bhold;
  endfunction

  // Drive one cycle of inputs at the falling edge.
  // At the rising edge, advance the model; shortly after, compare all outputs.
  task automatic cycle(input logic i_rd, input logic i_stall,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic i_we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] d, input string tag);
    @(negedge clk);
    rd_en = i_rd; stall = i_stall; ra_addr = ra; rb_addr = rb;
    we = i_we; wa_addr = wa; wd = d;
    @(posedge clk);
    if (!i_stall) begin
      if (!i_rd) begin
        // Pair retires: operands freeze at what they showed before this edge.
        m_ahold = exp_a();
        m_bhold = exp_b();
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_asrc  = ra;
        m_bsrc  = rb;
      end
    end
    if (i_we && wa != '0) m_regs[wa] = d;
    #1;
    check({tag, "_a"}, 32'(a_out), 32'(exp_a()));
    check({tag, "_b"}, 32'(b_out), 32'(exp_b()));
    check({tag, "_v"}, 32'(out_valid), 32'(m_valid));
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    check("rst_a", 32'(a_out), 32'h0);
    check("rst_v", 32'(out_valid), 32'h0);

    // Mid-operation asynchronous reset drops a valid pair immediately.
    cycle(0, 0, 0, 0, 1, 3'd1, 16'h0055, "pre_w");
    cycle(1, 0, 1, 1, 0, 0, 0, "pre_i");
    check("pre_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    rd_en = 1'b0; we = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_a", 32'(a_out), 32'h0);
    check("arst_b", 32'(b_out), 32'h0);
    check("arst_v", 32'(out_valid), 32'h0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < NR; i++) cycle(1, 0, AW'(i), AW'(i), 0, 0, 0, "zero_rd");

    // Write r3, then read it next to r0.
    cycle(0, 0, 0, 0, 1, 3'd3, 16'h1234, "t2_w");
    cycle(1, 0, 3'd3, 3'd0, 0, 0, 0, "t2_r");
    check("t2_a", 32'(a_out), 32'h1234);
    check("t2_b", 32'(b_out), 32'h0);
    check("t2_v", 32'(out_valid), 32'h1);

    // A write to r0 is discarded.
    cycle(0, 0, 0, 0, 1, 3'd0, 16'hFFFF, "t3_w");
    cycle(1, 0, 3'd0, 3'd0, 0, 0, 0, "t3_r");
    check("t3_a", 32'(a_out), 32'h0);

    // Same-cycle bypass to both ports.
    cycle(1, 0, 3'd5, 3'd5, 1, 3'd5, 16'h00A5, "t4");
    check("t4_a", 32'(a_out), 32'h00A5);
    check("t4_b", 32'(b_out), 32'h00A5);

    // Stall refresh of a held operand.
    cycle(0, 0, 0, 0, 1, 3'd2, 16'd7, "t5_w2");
    cycle(0, 0, 0, 0, 1, 3'd4, 16'd9, "t5_w4");
    cycle(1, 0, 3'd2, 3'd4, 0, 0, 0, "t5_i");
    cycle(0, 1, 0, 0, 1, 3'd2, 16'h0040, "t5_s");
    check("t5_a", 32'(a_out), 32'h0040);
    check("t5_b", 32'(b_out), 32'd9);
    check("t5_v", 32'(out_valid), 32'h1);
    cycle(0, 0, 0, 0, 0, 0, 0, "t5_rel");
    check("t5_rel_v", 32'(out_valid), 32'h0);

    // A stall ignores issue requests; writes to other registers still land.
    cycle(1, 0, 3'd2, 3'd4, 0, 0, 0, "t6_i");
    cycle(1, 1, 3'd6, 3'd6, 1, 3'd1, 16'hBEEF, "t6_s");
    check("t6_a", 32'(a_out), 32'h0040);
    check("t6_b", 32'(b_out), 32'd9);
    cycle(1, 0, 3'd1, 3'd6, 0, 0, 0, "t6_r");
    check("t6_r1", 32'(a_out), 32'hBEEF);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
            ($urandom_range(0, 1) == 1), AW'($urandom_range(0, NR - 1)),
            DW'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
